// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_sequencer: owns the PC, fetches 16-bit instructions and issues     |
// | them to the BittyPro execute unit. Optional macro: FETCH_SEQ_TIMEOUT_EN. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]       HALT_OP  = 16'hFFFF,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [15:0]       mem_data,
  output logic [15:0]       inst,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       inst_q, inst_d;
  logic              error_q, error_d;
  logic              timed_out;

`ifdef FETCH_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ISSUE always precedes EXEC, so clearing there clears on EXEC entry
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if ((state_q == S_EXEC) && !exec_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timed_out = (state_q == S_EXEC) && !exec_done && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_valid) begin
          inst_d  = mem_data;
          state_d = (mem_data == HALT_OP) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // A done in the timeout cycle wins over the timeout
        if (exec_done) begin
          pc_d    = pc_load ? pc_load_val : pc_q + ADDR_W'(1);
          state_d = run ? S_FETCH : S_IDLE;
        end else if (timed_out) begin
          error_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      error_q <= error_d;
    end
  end

  assign mem_req    = (state_q == S_FETCH);
  assign mem_addr   = pc_q;
  assign inst       = inst_q;
  assign exec_start = (state_q == S_ISSUE);
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_sequencer: randomized and directed bench for fetch_sequencer,   |
// | checked every cycle against a transaction-level reference model.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic [15:0] inst;
  logic        exec_start;
  logic        exec_done;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic [7:0]  pc;
  logic        halted;
  logic        error;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .inst(inst), .exec_start(exec_start), .exec_done(exec_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .pc(pc), .halted(halted), .error(error)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] mem [256];
  bit          rand_mode;
  int          done_div;
  bit          run_dir, drop_run_on_fetch, stray_idle, stray_fetch;
  int          valid_delay, fcnt, dly, starts;
  logic [15:0] inst_log[$];
  logic [7:0]  pc_log[$];

  // Reference model: what the sequencer is doing, in instruction-level terms
  typedef enum int {P_IDLE, P_FETCH, P_ISSUE, P_EXEC, P_HALT} phase_t;
  phase_t      m_ph;
  int          m_pc;
  logic [15:0] m_inst;
  bit          m_err;
  int          m_wait;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= P_IDLE; m_pc <= 0; m_inst <= 16'h0; m_err <= 1'b0; m_wait <= 0;
    end else begin
      case (m_ph)
        P_IDLE:  if (run) m_ph <= P_FETCH;
        P_FETCH: if (mem_valid) begin
          m_inst <= mem_data;
          m_ph   <= (mem_data == 16'hFFFF) ? P_HALT : P_ISSUE;
        end
        P_ISSUE: begin m_ph <= P_EXEC; m_wait <= 0; end
        P_EXEC: begin
          if (exec_done) begin
            m_pc <= pc_load ? int'(pc_load_val) : (m_pc + 1) % 256;
            m_ph <= run ? P_FETCH : P_IDLE;
          end
`ifdef FETCH_SEQ_TIMEOUT_EN
          else if (m_wait + 1 == 15) begin
            m_err <= 1'b1;
            m_pc  <= (m_pc + 1) % 256;
            m_ph  <= run ? P_FETCH : P_IDLE;
          end else begin
            m_wait <= m_wait + 1;
          end
`endif
        end
        default: m_ph <= m_ph;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("mem_req",    16'(mem_req),    16'(m_ph == P_FETCH));
    chk("mem_addr",   16'(mem_addr),   16'(m_pc));
    chk("inst",       inst,            m_inst);
    chk("exec_start", 16'(exec_start), 16'(m_ph == P_ISSUE));
    chk("pc",         16'(pc),         16'(m_pc));
    chk("halted",     16'(halted),     16'(m_ph == P_HALT));
    chk("error",      16'(error),      16'(m_err));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_req"},    16'(mem_req),    16'h0);
    chk({tag, "_mem_addr"},   16'(mem_addr),   16'h0);
    chk({tag, "_inst"},       inst,            16'h0);
    chk({tag, "_exec_start"}, 16'(exec_start), 16'h0);
    chk({tag, "_pc"},         16'(pc),         16'h0);
    chk({tag, "_halted"},     16'(halted),     16'h0);
    chk({tag, "_error"},      16'(error),      16'h0);
  endtask

  task automatic drive();
    if (exec_start === 1'b1) begin
      starts++;
      inst_log.push_back(inst);
      pc_log.push_back(pc);
    end
    if (rand_mode) begin
      run         = ($urandom_range(0, 7) != 0);
      mem_valid   = ($urandom_range(0, 2) == 0);
      mem_data    = mem_valid ? mem[mem_addr] : 16'($urandom);
      exec_done   = ($urandom_range(0, done_div - 1) == 0);
      pc_load     = 1'($urandom_range(0, 1));
      pc_load_val = 8'($urandom);
    end else begin
      if (drop_run_on_fetch && mem_req) run_dir = 1'b0;
      run         = run_dir;
      fcnt        = mem_req ? fcnt + 1 : 0;
      mem_valid   = mem_req && (fcnt > valid_delay);
      mem_data    = mem[mem_addr];
      exec_done   = 1'b0;
      pc_load     = 1'b0;
      pc_load_val = 8'($urandom);
      // Execute-unit stand-in: done two cycles after start, 0xBxxx branches, 0x5555 never finishes
      if (exec_start && inst != 16'h5555) begin
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          exec_done   = 1'b1;
          pc_load     = (inst[15:12] == 4'hB);
          pc_load_val = inst[7:0];
        end
      end
      if (stray_idle || (stray_fetch && mem_req)) exec_done = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_model();
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; mem_valid = 1'b0; mem_data = 16'h0;
    exec_done = 1'b0; pc_load = 1'b0; pc_load_val = 8'h0;
    rand_mode = 1'b0; run_dir = 1'b0; drop_run_on_fetch = 1'b0;
    stray_idle = 1'b0; stray_fetch = 1'b0; valid_delay = 0; done_div = 3;
    fcnt = 0; dly = -1; starts = 0;
    inst_log.delete(); pc_log.delete();
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    compare_model();
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    reset = 1'b1;

    // Straight-line program ending in HALT
    do_reset();
    clear_mem();
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456; mem[3] = 16'hFFFF;
    run_dir = 1'b1;
    repeat (40) step();
    chk("a_starts", 16'(starts), 16'd3);
    if (inst_log.size() >= 3) begin
      chk("a_inst0", inst_log[0], 16'h1234);
      chk("a_inst1", inst_log[1], 16'h2345);
      chk("a_inst2", inst_log[2], 16'h3456);
    end
    chk("a_halted",  16'(halted),  16'h1);
    chk("a_pc",      16'(pc),      16'h3);
    chk("a_mem_req", 16'(mem_req), 16'h0);

    // Branch to 0x40, branch to 0xFF, then increment wraps to 0x00
    do_reset();
    clear_mem();
    mem[8'h00] = 16'hB040; mem[8'h40] = 16'hB0FF; mem[8'hFF] = 16'h1357;
    run_dir = 1'b1;
    repeat (30) step();
    chk("b_starts_ge4", 16'(starts >= 4), 16'h1);
    if (pc_log.size() >= 4) begin
      chk("b_addr0", 16'(pc_log[0]), 16'h00);
      chk("b_addr1", 16'(pc_log[1]), 16'h40);
      chk("b_addr2", 16'(pc_log[2]), 16'hFF);
      chk("b_addr3", 16'(pc_log[3]), 16'h00);
    end

    // Stray exec_done in IDLE/FETCH, run drops mid-fetch with a slow memory
    do_reset();
    clear_mem();
    mem[0] = 16'h1111;
    stray_idle = 1'b1;
    repeat (3) step();
    stray_idle = 1'b0;
    stray_fetch = 1'b1; drop_run_on_fetch = 1'b1; valid_delay = 4; run_dir = 1'b1;
    repeat (20) step();
    chk("c_starts", 16'(starts), 16'd1);
    chk("c_pc",     16'(pc),     16'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("c_idle_mem_req", 16'(mem_req), 16'h0);
    end

    // Asynchronous reset between edges while an instruction is executing
    do_reset();
    clear_mem();
    mem[8'h00] = 16'hB020; mem[8'h20] = 16'h5555;
    run_dir = 1'b1;
    for (int i = 0; i < 40 && starts < 2; i++) step();
    chk("d_reach_exec", 16'(starts), 16'd2);
    step(); step();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_reset_values("async");
    compare_model();

    // Execute unit that never finishes
    do_reset();
    clear_mem();
    mem[0] = 16'h5555; mem[1] = 16'hFFFF;
    run_dir = 1'b1;
    repeat (40) step();
`ifdef FETCH_SEQ_TIMEOUT_EN
    chk("e_error",  16'(error),  16'h1);
    chk("e_halted", 16'(halted), 16'h1);
    chk("e_pc",     16'(pc),     16'h1);
`else
    chk("e_error",  16'(error),  16'h0);
    chk("e_halted", 16'(halted), 16'h0);
    chk("e_pc",     16'(pc),     16'h0);
`endif

    // Randomized segments; some with a sluggish execute unit
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 63) == 0) ? 16'hFFFF : 16'($urandom);
      done_div  = (seg % 4 == 3) ? 24 : 3;
      rand_mode = 1'b1;
      repeat (300) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
